// File: rtl/ipf_pkg.sv
// rtl/ipf_pkg.sv - shared types for the instruction prefetch buffer
package ipf_pkg;

  // Fetch sequencer: at most one ICache request outstanding at any time.
  typedef enum logic {
    ISSUE     = 1'b0,
    WAIT_RESP = 1'b1
  } ipf_state_t;

  // One queued instruction word together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ipf_fifo.sv
// rtl/ipf_fifo.sv - synchronous FIFO of fetch entries with flush and occupancy count
module ipf_fifo
  import ipf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;

  // Pointers and count; flush discards every entry in one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (!push_i && pop_i) count_q <= count_q - CW'(1);
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !reset_i) mem_q[wptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - sequential ICache fetcher and decode queue; IPF_BYPASS_EN enables empty-queue bypass
module inst_prefetch_buffer
  import ipf_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ireq_valid_o,
  output logic [31:0] ireq_addr_o,
  input  logic        ireq_ready_i,
  input  logic        iresp_valid_i,
  input  logic [31:0] iresp_addr_i,
  input  logic [31:0] iresp_rdata_i,
  output logic        iresp_ready_o,
  output logic        ptw_kill_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  ipf_state_t    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_q, inflight_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          fifo_nonempty;
  logic          issue;
  logic          handshake;
  logic          resp_hit;
  logic          push;
  logic          pop;

  assign fifo_nonempty = (count != '0);

  // A request is only raised while a FIFO slot is free for the word it will return.
  assign issue        = (state_q == ISSUE) && (count < CW'(DEPTH)) && !reset_i && !redirect_valid_i;
  assign handshake    = issue && ireq_ready_i;
  assign ireq_valid_o = issue;
  assign ireq_addr_o  = fetch_pc_q;

  // Only the response for the outstanding address counts; anything else is ignored.
  assign resp_hit = (state_q == WAIT_RESP) && iresp_valid_i && (iresp_addr_i == inflight_q)
                    && !redirect_valid_i && !reset_i;

  assign iresp_ready_o = 1'b1;
  assign ptw_kill_o    = reset_i || redirect_valid_i;

  assign pop        = !reset_i && !redirect_valid_i && fifo_nonempty && out_ready_i;
  assign push_entry = '{pc: inflight_q, inst: iresp_rdata_i};

`ifdef IPF_BYPASS_EN
  logic bypass;
  assign bypass      = resp_hit && !fifo_nonempty;
  assign out_valid_o = !reset_i && (fifo_nonempty || bypass);
  assign out_pc_o    = bypass ? inflight_q    : head.pc;
  assign out_inst_o  = bypass ? iresp_rdata_i : head.inst;
  assign push        = resp_hit && !(bypass && out_ready_i);
`else
  assign out_valid_o = !reset_i && fifo_nonempty;
  assign out_pc_o    = head.pc;
  assign out_inst_o  = head.inst;
  assign push        = resp_hit;
`endif

  ipf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (redirect_valid_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  // Next fetch state; a redirect abandons whatever request is in flight.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    if (redirect_valid_i) begin
      state_d    = ISSUE;
      fetch_pc_d = redirect_pc_i;
    end else begin
      case (state_q)
        ISSUE: begin
          if (handshake) begin
            state_d    = WAIT_RESP;
            inflight_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        WAIT_RESP: begin
          if (resp_hit) state_d = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ISSUE;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - directed and randomized bench for inst_prefetch_buffer
module tb_inst_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        ireq_valid_o;
  logic [31:0] ireq_addr_o;
  logic        ireq_ready_i = 1'b0;
  logic        iresp_valid_i = 1'b0;
  logic [31:0] iresp_addr_i = '0;
  logic [31:0] iresp_rdata_i = '0;
  logic        iresp_ready_o;
  logic        ptw_kill_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .ireq_valid_o     (ireq_valid_o),
    .ireq_addr_o      (ireq_addr_o),
    .ireq_ready_i     (ireq_ready_i),
    .iresp_valid_i    (iresp_valid_i),
    .iresp_addr_i     (iresp_addr_i),
    .iresp_rdata_i    (iresp_rdata_i),
    .iresp_ready_o    (iresp_ready_o),
    .ptw_kill_o       (ptw_kill_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_pc_o         (out_pc_o),
    .out_inst_o       (out_inst_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch address, outstanding request, queue of delivered words.
  logic [31:0] m_fetch;
  bit          m_wait;
  logic [31:0] m_inflight;
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];

  // Memory responder.
  bit          auto_resp = 0;
  bit          bogus_en = 0;
  int          resp_delay = 0;
  bit          mem_pending = 0;
  logic [31:0] mem_addr = '0;
  int          mem_delay = 0;
  bit          sent_pending;

  // Events seen in the current cycle.
  bit          e_hs, e_resp, e_pop, obs_hs;
  logic [31:0] obs_hs_addr;
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // First half of a cycle: drive responder, move to negedge, compare against the model.
  task automatic step_a();
    bit exp_iv, exp_ov, byp;
    logic [31:0] exp_pc, exp_inst;
    sent_pending = 0;
    if (auto_resp) begin
      if (mem_pending && mem_delay == 0) begin
        iresp_valid_i = 1'b1;
        iresp_addr_i  = mem_addr;
        iresp_rdata_i = inst_of(mem_addr);
        sent_pending  = 1;
      end else if (bogus_en && mem_pending && $urandom_range(0, 3) == 0) begin
        iresp_valid_i = 1'b1;
        iresp_addr_i  = mem_addr ^ 32'h40;
        iresp_rdata_i = $urandom;
      end else begin
        iresp_valid_i = 1'b0;
        iresp_addr_i  = $urandom;
        iresp_rdata_i = $urandom;
      end
    end
    #4;
    e_resp = !reset_i && !redirect_valid_i && m_wait && iresp_valid_i && (iresp_addr_i == m_inflight);
    byp = 0;
`ifdef IPF_BYPASS_EN
    byp = e_resp && (q_pc.size() == 0);
`endif
    exp_iv = !reset_i && !redirect_valid_i && !m_wait && (q_pc.size() < DEPTH);
    exp_ov = !reset_i && ((q_pc.size() != 0) || byp);
    chk("ptw_kill", ptw_kill_o, reset_i | redirect_valid_i);
    chk("iresp_ready", iresp_ready_o, 1);
    chk("ireq_valid", ireq_valid_o, exp_iv);
    if (exp_iv) chk("ireq_addr", ireq_addr_o, m_fetch);
    chk("out_valid", out_valid_o, exp_ov);
    if (exp_ov) begin
      exp_pc   = byp ? m_inflight : q_pc[0];
      exp_inst = byp ? iresp_rdata_i : q_inst[0];
      chk("out_pc", out_pc_o, exp_pc);
      chk("out_inst", out_inst_o, exp_inst);
    end
    e_hs  = exp_iv && ireq_ready_i;
    e_pop = exp_ov && out_ready_i && !redirect_valid_i;
    obs_hs      = ireq_valid_o && ireq_ready_i;
    obs_hs_addr = ireq_addr_o;
    if (obs_hs) hs_log.push_back(ireq_addr_o);
    if (out_valid_o && out_ready_i && !redirect_valid_i && !reset_i) pop_log.push_back(out_pc_o);
  endtask

  // Second half: advance model and responder, then move to just after the next edge.
  task automatic step_b();
    bit consumed;
    if (reset_i) begin
      m_fetch = RESET_PC; m_wait = 0; q_pc.delete(); q_inst.delete();
    end else if (redirect_valid_i) begin
      m_fetch = redirect_pc_i; m_wait = 0; q_pc.delete(); q_inst.delete();
    end else begin
      consumed = e_pop && (q_pc.size() == 0);
      if (e_pop && q_pc.size() != 0) begin
        void'(q_pc.pop_front()); void'(q_inst.pop_front());
      end
      if (e_resp) begin
        m_wait = 0;
        if (!consumed) begin q_pc.push_back(m_inflight); q_inst.push_back(iresp_rdata_i); end
      end
      if (e_hs) begin
        m_wait = 1; m_inflight = m_fetch; m_fetch = m_fetch + 32'd4;
      end
    end
    if (sent_pending) mem_pending = 0;
    else if (mem_pending && mem_delay > 0) mem_delay--;
    if (obs_hs) begin
      mem_pending = 1; mem_addr = obs_hs_addr; mem_delay = resp_delay;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    step_a();
    step_b();
  endtask

  task automatic do_reset();
    reset_i = 1'b1; redirect_valid_i = 1'b0; ireq_ready_i = 1'b0; out_ready_i = 1'b0;
    auto_resp = 0; bogus_en = 0; iresp_valid_i = 1'b0; mem_pending = 0;
    cycle();
    cycle();
    reset_i = 1'b0;
    hs_log.delete(); pop_log.delete();
  endtask

  initial begin
    logic [31:0] r;
    m_fetch = RESET_PC; m_wait = 0; m_inflight = '0;
    @(posedge clk);
    #1;

    // 1: sequential fetch with always-ready memory and 1-cycle response
    do_reset();
    ireq_ready_i = 1'b1; out_ready_i = 1'b1; auto_resp = 1; resp_delay = 0;
    repeat (12) cycle();
    if (hs_log.size() >= 3 && pop_log.size() >= 3) begin
      chk("t1_req0", hs_log[0], 32'h0);
      chk("t1_req1", hs_log[1], 32'h4);
      chk("t1_req2", hs_log[2], 32'h8);
      chk("t1_out0", pop_log[0], 32'h0);
      chk("t1_out1", pop_log[1], 32'h4);
      chk("t1_out2", pop_log[2], 32'h8);
    end else chk("t1_counts", hs_log.size(), 3);

    // 2: decode stalled -> exactly DEPTH fetches, then resume at 0x10
    do_reset();
    ireq_ready_i = 1'b1; out_ready_i = 1'b0; auto_resp = 1; resp_delay = 0;
    repeat (20) cycle();
    chk("t2_hs_count", hs_log.size(), DEPTH);
    step_a();
    chk("t2_stalled_valid", ireq_valid_o, 0);
    step_b();
    out_ready_i = 1'b1;
    for (int i = 0; i < 10 && hs_log.size() < 5; i++) cycle();
    if (hs_log.size() >= 5) chk("t2_resume_addr", hs_log[4], 32'h10);
    else chk("t2_resume_timeout", hs_log.size(), 5);

    // 3: ireq_ready low holds valid and addr 0x8 stable
    do_reset();
    ireq_ready_i = 1'b1; out_ready_i = 1'b1; auto_resp = 1; resp_delay = 0;
    for (int i = 0; i < 20 && hs_log.size() < 2; i++) cycle();
    ireq_ready_i = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 5; i++) begin
      step_a();
      chk("t3_hold_valid", ireq_valid_o, 1);
      chk("t3_hold_addr", ireq_addr_o, 32'h8);
      step_b();
    end
    ireq_ready_i = 1'b1;
    repeat (4) cycle();

    // 4: redirect while waiting for 0xC
    do_reset();
    ireq_ready_i = 1'b1; out_ready_i = 1'b0; auto_resp = 1; resp_delay = 2;
    for (int i = 0; i < 40 && hs_log.size() < 4; i++) cycle();
    if (hs_log.size() >= 4) chk("t4_req3", hs_log[3], 32'hC);
    else chk("t4_timeout", hs_log.size(), 4);
    auto_resp = 0; iresp_valid_i = 1'b0; ireq_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h1000;
    step_a();
    chk("t4_kill", ptw_kill_o, 1);
    step_b();
    redirect_valid_i = 1'b0;
    iresp_valid_i = 1'b1; iresp_addr_i = 32'hC; iresp_rdata_i = inst_of(32'hC);
    step_a();
    chk("t4_flushed", out_valid_o, 0);
    chk("t4_new_addr", ireq_addr_o, 32'h1000);
    step_b();
    iresp_valid_i = 1'b0;
    step_a();
    chk("t4_late_drop", out_valid_o, 0);
    step_b();
    ireq_ready_i = 1'b1;
    cycle();
    chk("t4_hs_redirect", hs_log[hs_log.size()-1], 32'h1000);

    // 5: mismatching response dropped, matching one pushed
    do_reset();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
    cycle();
    redirect_valid_i = 1'b0; ireq_ready_i = 1'b1;
    cycle();
    ireq_ready_i = 1'b0;
    iresp_valid_i = 1'b1; iresp_addr_i = 32'h44; iresp_rdata_i = 32'hDEAD_BEEF;
    cycle();
    iresp_valid_i = 1'b0;
    step_a();
    chk("t5_mismatch_drop", out_valid_o, 0);
    step_b();
    iresp_valid_i = 1'b1; iresp_addr_i = 32'h40; iresp_rdata_i = inst_of(32'h40);
    cycle();
    iresp_valid_i = 1'b0;
    step_a();
    chk("t5_match_valid", out_valid_o, 1);
    chk("t5_match_pc", out_pc_o, 32'h40);
    step_b();

    // 6: fetch address wraps past 0xFFFF_FFFC
    do_reset();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    cycle();
    redirect_valid_i = 1'b0; ireq_ready_i = 1'b1; out_ready_i = 1'b1; auto_resp = 1; resp_delay = 0;
    hs_log.delete();
    for (int i = 0; i < 30 && hs_log.size() < 3; i++) cycle();
    if (hs_log.size() >= 3) begin
      chk("t6_pre_wrap", hs_log[1], 32'hFFFF_FFFC);
      chk("t6_wrap", hs_log[2], 32'h0);
    end else chk("t6_timeout", hs_log.size(), 3);

    // Randomized traffic against the model
    bogus_en = 1;
    for (int i = 0; i < 3000; i++) begin
      ireq_ready_i = ($urandom_range(0, 3) != 0);
      out_ready_i  = ($urandom_range(0, 2) != 0);
      resp_delay   = $urandom_range(0, 3);
      redirect_valid_i = ($urandom_range(0, 39) == 0);
      r = $urandom;
      r[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0;
      redirect_pc_i = r;
      reset_i = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset_i = 1'b0; redirect_valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
